mux_2a1: RTL and testbench
==========================

MUX_2A1 -- requirements
Module: mux_2a1

Interface
REQ-001 Parameter WIDTH, default 3: data width of A, B and F.
REQ-002 Port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 Port A, input, WIDTH bits: data operand selected when s0=0.
REQ-005 Port B, input, WIDTH bits: data operand selected when s0=1.
REQ-006 Port s0, input, 1 bit: select line; 0 selects A, 1 selects B.
REQ-007 Port en, input, 1 bit: load enable; 1 captures the new selection, 0 holds F.
REQ-008 Port F, output, WIDTH bits: registered mux result.
REQ-009 Port F_par, output, 1 bit: even parity of F; present only when MUX_2A1_PARITY_EN is defined.

Function
REQ-010 Next-state selection: sel_d = (s0 == 0) ? A : B, bitwise over all WIDTH bits.
REQ-011 On a rising clk edge with rst=0 and en=1, F SHALL load sel_d; latency is exactly one cycle from input sampling to F.
REQ-012 On a rising clk edge with rst=0 and en=0, F SHALL retain its previous value regardless of A, B or s0.
REQ-013 F SHALL change only on rising clk edges; no combinational path from A, B, s0 or en to F.
REQ-014 s0 toggling together with A or B in the same cycle: the value sampled at the edge decides; there is no glitch or intermediate value on F.
REQ-015 When A equals B, F SHALL equal A irrespective of s0.
REQ-016 X or Z on s0 is not a legal input; the bench SHALL drive s0 to 0 or 1 only.

Reset
REQ-017 With rst=1 at a rising clk edge, F SHALL become all zeros, with priority over en.
REQ-018 Reset asserted in the middle of streaming data SHALL discard the pending selection. The first load after release SHALL occur on the first edge with rst=0 and en=1.
REQ-019 F_par SHALL read 0 during and immediately after reset, when enabled.

Configuration
REQ-020 Macro MUX_2A1_PARITY_EN, when defined, SHALL add a parity register. On each edge that loads F, it SHALL load the XOR-reduction of sel_d. On reset it SHALL clear to 0, and it SHALL hold when en=0, so that F_par always equals ^F.
REQ-021 When MUX_2A1_PARITY_EN is undefined, port F_par and its register SHALL be absent, and all other behaviour is unchanged.

Structure
REQ-022 Package mux_2a1_pkg SHALL hold: the WIDTH default constant (3), and the select encoding constants SEL_A=1'b0 and SEL_B=1'b1.
REQ-023 Sub-module mux_2a1_core SHALL implement the purely combinational WIDTH-bit 2:1 selection (A, B, s0 -> sel_d).
REQ-024 The top module mux_2a1 SHALL instantiate mux_2a1_core and own all registers.

Verification
REQ-025 Reset: rst=1 for 2 cycles with A=3'b101, B=3'b011, s0=1, en=1 -> F=3'b000 (F_par=0). After release, the next edge gives F=3'b011.
REQ-026 Select sweep, en=1, one vector per cycle; each F is checked one cycle later:
- A=000, B=001, s0=0 -> F=000
- A=001, B=000, s0=1 -> F=000
- A=010, B=011, s0=0 -> F=010
- A=011, B=010, s0=1 -> F=010
- A=100, B=101, s0=1 -> F=101
- A=011, B=000, s0=0 -> F=011
REQ-027 Equal operands: A=B=3'b100 with s0=0, then A=B=3'b101 with s0=1 -> F=100, then F=101.
REQ-028 Hold: load F=3'b010, then en=0 for 3 cycles while A=111, B=111 and s0 toggles -> F stays 010. Setting en=1 with s0=0 -> F=111 next cycle.
REQ-029 Mid-stream reset: during the REQ-026 sweep, pulse rst=1 for one edge -> F=000 on that edge. The sweep then resumes with correct one-cycle latency.
REQ-030 Parity build (MUX_2A1_PARITY_EN defined): A=3'b111, s0=0 -> F=111, F_par=1. Then B=3'b011, s0=1 -> F=011, F_par=0.

Source files
------------

// File: rtl/mux_2a1_pkg.sv
// Shared constants for the registered 2:1 mux slice.
// The optional parity feature is enabled by defining MUX_2A1_PARITY_EN.
package mux_2a1_pkg;

    localparam int unsigned WIDTH_DEF = 3;

    typedef logic sel_t;

    localparam sel_t SEL_A = 1'b0;
    localparam sel_t SEL_B = 1'b1;

endpackage : mux_2a1_pkg

// File: rtl/mux_2a1_if.sv
// Operand/select/result bundle for mux_2a1; F_par exists only when
// MUX_2A1_PARITY_EN is defined.
interface mux_2a1_if
    import mux_2a1_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
);

    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             s0;
    logic             en;
    logic [WIDTH-1:0] F;
`ifdef MUX_2A1_PARITY_EN
    logic             F_par;
`endif

`ifdef MUX_2A1_PARITY_EN
    modport master (output A, output B, output s0, output en, input F, input F_par);
    modport slave  (input A, input B, input s0, input en, output F, output F_par);
`else
    modport master (output A, output B, output s0, output en, input F);
    modport slave  (input A, input B, input s0, input en, output F);
`endif

endinterface : mux_2a1_if

// File: rtl/mux_2a1_core.sv
// Purely combinational WIDTH-bit 2:1 selection feeding the output register.
module mux_2a1_core
    import mux_2a1_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  sel_t             s0,
    output logic [WIDTH-1:0] sel_d
);

    always_comb begin
        sel_d = (s0 == SEL_A) ? A : B;
    end

endmodule : mux_2a1_core

// File: rtl/mux_2a1.sv
// Registered 2:1 mux with load enable and synchronous reset.
// Defining MUX_2A1_PARITY_EN adds a registered even-parity output F_par.
module mux_2a1
    import mux_2a1_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic      clk,
    input  logic      rst,
    mux_2a1_if.slave  bus
);

    logic [WIDTH-1:0] sel_d;
    logic [WIDTH-1:0] f_q;

    mux_2a1_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .A     (bus.A),
        .B     (bus.B),
        .s0    (bus.s0),
        .sel_d (sel_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            f_q <= '0;
        end else if (bus.en) begin
            f_q <= sel_d;
        end
    end

    assign bus.F = f_q;

`ifdef MUX_2A1_PARITY_EN
    logic par_q;

    // Loaded from sel_d on the same edges as f_q, so it always tracks ^F.
    always_ff @(posedge clk) begin
        if (rst) begin
            par_q <= 1'b0;
        end else if (bus.en) begin
            par_q <= ^sel_d;
        end
    end

    assign bus.F_par = par_q;
`endif

endmodule : mux_2a1

// File: tb/tb_mux_2a1.sv
// Directed self-checking bench for mux_2a1; parity checks are compiled in
// when MUX_2A1_PARITY_EN is defined.
module tb_mux_2a1;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    mux_2a1_if #(.WIDTH(3)) bus ();

    mux_2a1 #(.WIDTH(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [2:0] SW_A [6] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b011};
    localparam logic [2:0] SW_B [6] = '{3'b001, 3'b000, 3'b011, 3'b010, 3'b101, 3'b000};
    localparam logic       SW_S [6] = '{1'b0,   1'b1,   1'b0,   1'b1,   1'b1,   1'b0};
    localparam logic [2:0] SW_F [6] = '{3'b000, 3'b000, 3'b010, 3'b010, 3'b101, 3'b011};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.A = 3'b101; bus.B = 3'b011; bus.s0 = 1'b1; bus.en = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (bus.F !== 3'b000) begin
                errors++;
                $display("FAIL reset_F cycle %0d: got %b expected 000", i, bus.F);
            end
`ifdef MUX_2A1_PARITY_EN
            checks++;
            if (bus.F_par !== 1'b0) begin
                errors++;
                $display("FAIL reset_par cycle %0d: got %b expected 0", i, bus.F_par);
            end
`endif
        end
        rst = 1'b0;
`ifdef MUX_2A1_PARITY_EN
        checks++;
        if (bus.F_par !== 1'b0) begin
            errors++;
            $display("FAIL reset_par_after: got %b expected 0", bus.F_par);
        end
`endif
        tick();
        checks++;
        if (bus.F !== 3'b011) begin
            errors++;
            $display("FAIL reset_release_F: got %b expected 011", bus.F);
        end
    endtask

    task automatic test_select_sweep();
        bus.en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.A = SW_A[i]; bus.B = SW_B[i]; bus.s0 = SW_S[i];
            tick();
            checks++;
            if (bus.F !== SW_F[i]) begin
                errors++;
                $display("FAIL sweep_%0d: got %b expected %b", i, bus.F, SW_F[i]);
            end
        end
    endtask

    task automatic test_equal_operands();
        bus.en = 1'b1;
        bus.A = 3'b100; bus.B = 3'b100; bus.s0 = 1'b0;
        tick();
        checks++;
        if (bus.F !== 3'b100) begin
            errors++;
            $display("FAIL equal_s0_0: got %b expected 100", bus.F);
        end
        bus.A = 3'b101; bus.B = 3'b101; bus.s0 = 1'b1;
        tick();
        checks++;
        if (bus.F !== 3'b101) begin
            errors++;
            $display("FAIL equal_s0_1: got %b expected 101", bus.F);
        end
    endtask

    task automatic test_hold();
        bus.en = 1'b1;
        bus.A = 3'b010; bus.B = 3'b101; bus.s0 = 1'b0;
        tick();
        checks++;
        if (bus.F !== 3'b010) begin
            errors++;
            $display("FAIL hold_load: got %b expected 010", bus.F);
        end
        bus.en = 1'b0;
        bus.A = 3'b111; bus.B = 3'b111;
        for (int i = 0; i < 3; i++) begin
            bus.s0 = i[0];
            tick();
            checks++;
            if (bus.F !== 3'b010) begin
                errors++;
                $display("FAIL hold_cycle_%0d: got %b expected 010", i, bus.F);
            end
        end
        bus.en = 1'b1; bus.s0 = 1'b0;
        tick();
        checks++;
        if (bus.F !== 3'b111) begin
            errors++;
            $display("FAIL hold_release: got %b expected 111", bus.F);
        end
    endtask

    task automatic test_midstream_reset();
        bus.en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.A = SW_A[i]; bus.B = SW_B[i]; bus.s0 = SW_S[i];
            if (i == 3) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                checks++;
                if (bus.F !== 3'b000) begin
                    errors++;
                    $display("FAIL midreset_F: got %b expected 000", bus.F);
                end
            end
            tick();
            checks++;
            if (bus.F !== SW_F[i]) begin
                errors++;
                $display("FAIL midreset_sweep_%0d: got %b expected %b", i, bus.F, SW_F[i]);
            end
        end
    endtask

`ifdef MUX_2A1_PARITY_EN
    task automatic test_parity();
        bus.en = 1'b1;
        bus.A = 3'b111; bus.B = 3'b000; bus.s0 = 1'b0;
        tick();
        checks++;
        if (bus.F !== 3'b111 || bus.F_par !== 1'b1) begin
            errors++;
            $display("FAIL parity_111: got F=%b par=%b expected F=111 par=1", bus.F, bus.F_par);
        end
        bus.B = 3'b011; bus.s0 = 1'b1;
        tick();
        checks++;
        if (bus.F !== 3'b011 || bus.F_par !== 1'b0) begin
            errors++;
            $display("FAIL parity_011: got F=%b par=%b expected F=011 par=0", bus.F, bus.F_par);
        end
        bus.en = 1'b0; bus.A = 3'b001; bus.s0 = 1'b0;
        tick();
        checks++;
        if (bus.F_par !== 1'b0) begin
            errors++;
            $display("FAIL parity_hold: got %b expected 0", bus.F_par);
        end
    endtask
`endif

    initial begin
        errors = 0;
        checks = 0;
        rst    = 1'b1;
        bus.A  = '0;
        bus.B  = '0;
        bus.s0 = 1'b0;
        bus.en = 1'b0;
        #2;
        test_reset();
        test_select_sweep();
        test_equal_operands();
        test_hold();
        test_midstream_reset();
`ifdef MUX_2A1_PARITY_EN
        test_parity();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_mux_2a1
